// File: rtl/fd_queue_pkg.sv
// fd_queue_pkg: shared fetch/decode payload type and the bubble presented when the queue is empty.
package common;
   typedef struct packed {
      logic [31:0] raw_instr;
      logic [31:0] pc;
      logic        stall;
   } fetch_data_t;
   localparam fetch_data_t FETCH_BUBBLE = '{raw_instr: 32'h0, pc: 32'h0, stall: 1'b1};
   function automatic fetch_data_t fd_live(input fetch_data_t d);
      fd_live       = d;
      fd_live.stall = 1'b0;
   endfunction
endpackage

// File: rtl/fdq_mem.sv
// fdq_mem: DEPTH-entry fetch_data_t register array, one write port, one asynchronous read port.
module fdq_mem import common::*; #(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  fetch_data_t   wdata,
   input  logic [PW-1:0] raddr,
   output fetch_data_t   rdata
);
   fetch_data_t mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we) mem_q[waddr] <= wdata;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/fd_queue.sv
// fd_queue: fetch-to-decode instruction queue with flush and decode-stall replay.
// Define FD_QUEUE_BYPASS_EN to let an entry reach decode in the same cycle when the queue is empty.
module fd_queue import common::*; #(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  fetch_data_t                  in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output fetch_data_t                  out_data,
   input  logic                         out_ready,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop, byp, empty;
   fetch_data_t   head;
   fdq_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .raddr (rd_ptr_q),
      .rdata (head)
   );
   always_comb begin
      empty     = count_q == '0;
`ifdef FD_QUEUE_BYPASS_EN
      byp       = empty && in_valid && !flush;
`else
      byp       = 1'b0;
`endif
      in_ready  = count_q != CW'(DEPTH);
      out_valid = (!empty || byp) && !flush;
      out_data  = !out_valid ? FETCH_BUBBLE : byp ? fd_live(in_data) : fd_live(head);
      // a bypassed entry consumed by decode never touches storage
      push      = in_valid && in_ready && !flush && !(byp && out_ready);
      pop       = out_valid && out_ready && !byp;
      wr_ptr_d  = flush ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = flush ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d   = flush ? '0 : (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   assign count = count_q;
endmodule

// File: tb/tb_fd_queue.sv
// tb_fd_queue: directed stimulus with a scoreboard of expected decode-side entries.
module tb_fd_queue;
   import common::*;
   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready, flush;
   fetch_data_t in_data, out_data;
   logic [2:0]  count;
   fetch_data_t sb[$];
   int          n_pass = 0, n_total = 0;
   fd_queue #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush), .count(count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", nm, got, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [31:0] raw, input logic [31:0] pc, input logic acc);
      in_valid = 1'b1;
      in_data  = '{raw_instr: raw, pc: pc, stall: 1'b1};
      if (acc) sb.push_back('{raw_instr: raw, pc: pc, stall: 1'b0});
   endtask
   task automatic put(input logic [31:0] raw, input logic [31:0] pc, input logic acc);
      drive(raw, pc, acc);
      step();
   endtask
   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) chk("unexpected_valid", out_valid, 0);
         else begin
            chk("head", out_data, sb[0]);
            if (out_ready) void'(sb.pop_front());
         end
      end else chk("bubble", out_data, FETCH_BUBBLE);
   end
   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      #2 reset = 1'b0;
      @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      step();
      reset = 1'b1;
      put(32'h13, 32'h8000_0000, 1);
      put(32'h93, 32'h8000_0004, 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("two_count", count, 2);
      chk("two_head_pc", out_data.pc, 32'h8000_0000);
      step();
      @(negedge clk);
      chk("two_held_pc", out_data.pc, 32'h8000_0000);
      chk("two_held_stall", out_data.stall, 0);
      step();
      put(32'h113, 32'h8000_0008, 1);
      put(32'h193, 32'h8000_000c, 1);
      drive(32'h213, 32'h8000_0010, 0);
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("full_count", count, 4);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("fifth_rejected", count, 4);
      step();
      drive(32'h213, 32'h8000_0010, 0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("full_pop_in_ready", in_ready, 0);
      step();
      out_ready = 1'b0;
      sb.push_back('{raw_instr: 32'h213, pc: 32'h8000_0010, stall: 1'b0});
      @(negedge clk);
      chk("after_pop_count", count, 3);
      chk("after_pop_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("refill_count", count, 4);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre_flush_count", count, 3);
      step();
      drive(32'h313, 32'h9000_0000, 0);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      step();
      sb.delete();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_count", count, 0);
      chk("flush_out_valid_next", out_valid, 0);
      chk("flush_bubble", out_data, FETCH_BUBBLE);
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(32'h1000 + i, 32'h100 + 4 * i, 1);
         @(negedge clk);
         chk("wrap_count_le1", count <= 1, 1);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      chk("wrap_drained_count", count, 0);
      chk("wrap_all_seen", sb.size(), 0);
      step();
      drive(32'h0000_0013, 32'h200, 1);
      @(negedge clk);
`ifdef FD_QUEUE_BYPASS_EN
      chk("byp_same_valid", out_valid, 1);
      chk("byp_same_raw", out_data.raw_instr, 32'h13);
      chk("byp_same_count", count, 0);
`else
      chk("nobyp_same_valid", out_valid, 0);
`endif
      step();
      in_valid = 1'b0;
      @(negedge clk);
`ifdef FD_QUEUE_BYPASS_EN
      chk("byp_next_count", count, 0);
      chk("byp_next_valid", out_valid, 0);
`else
      chk("nobyp_next_count", count, 1);
      chk("nobyp_next_valid", out_valid, 1);
      chk("nobyp_next_raw", out_data.raw_instr, 32'h13);
`endif
      step();
      out_ready = 1'b0;
      put(32'h55, 32'h400, 1);
      put(32'h66, 32'h404, 1);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("midrst_count", count, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      sb.delete();
      step();
      reset = 1'b1;
      put(32'h77, 32'h500, 1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_count", count, 1);
      chk("post_rst_pc", out_data.pc, 32'h500);
      chk("post_rst_slot0", dut.u_mem.mem_q[0].pc, 32'h500);
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      @(negedge clk);
      chk("final_count", count, 0);
      chk("final_sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fd_queue.md
FD_QUEUE -- requirements
Module: fd_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered fetch entries; power of two, 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  fetch stage presents a fetched instruction.
REQ-005 Port: in_data  input  fetch_data_t  fetched raw_instr, pc, stall.
REQ-006 Port: in_ready  output  1  queue accepts in_data this cycle.
REQ-007 Port: out_valid  output  1  head entry presented to decode.
REQ-008 Port: out_data  output  fetch_data_t  head entry, or bubble when out_valid=0.
REQ-009 Port: out_ready  input  1  decode consumes head this cycle; low means decode stall.
REQ-010 Port: flush  input  1  redirect (branch/exception); discards all entries.
REQ-011 Port: count  output  $clog2(DEPTH+1)  number of valid entries.

Function
REQ-012 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-013 in_ready SHALL equal (count != DEPTH); no combinational path from out_ready to in_ready.
REQ-014 Push writes in_data at write pointer; pointers advance by one, wrapping DEPTH-1 -> 0.
REQ-015 Simultaneous push and pop SHALL leave count unchanged; push-only +1, pop-only -1.
REQ-016 Full with pop: entry freed, in_ready stays 0 that cycle; push accepted next cycle.
REQ-017 out_valid SHALL equal (count != 0) (bypass: see REQ-024); out_data SHALL be the oldest entry with stall=0.
REQ-018 When out_valid=0, out_data SHALL be the bubble: raw_instr=32'h0, pc=0, stall=1.
REQ-019 Head held stable across cycles while out_valid && !out_ready (replay on decode stall).
REQ-020 flush has priority: next cycle count=0, pointers equal, out_valid=0; same-cycle push discarded; out_valid forced 0 in the flush cycle.
REQ-021 Latency without bypass: entry pushed in cycle N visible at out_data in cycle N+1 if queue was empty.

Reset
REQ-022 reset low SHALL immediately clear count, read/write pointers; out_valid=0, out_data=bubble, in_ready=1; storage array not reset.
REQ-023 Reset asserted mid-operation discards all entries; first push after release lands at slot 0.

Configuration
REQ-024 Macro FD_QUEUE_BYPASS_EN defined: when count=0, in_valid=1, flush=0, out_valid=1 and out_data=in_data (stall forced 0) combinationally; if out_ready also 1, entry not written and count stays 0.
REQ-025 Macro FD_QUEUE_BYPASS_EN undefined: no combinational in->out path; REQ-021 latency applies; in_ready depends only on registered count.

Structure
REQ-026 fetch_data_t and a FETCH_BUBBLE constant (raw_instr 0, pc 0, stall 1) SHALL live in package common.
REQ-027 One sub-module fdq_mem: DEPTH x fetch_data_t register array, one write port, one asynchronous read port.
REQ-028 Pointer width $clog2(DEPTH); count kept as separate register, not derived from pointer difference.

Verification
REQ-029 Reset, push pc=0x8000_0000,0x8000_0004 with out_ready=0 -> count=2, out_data.pc=0x8000_0000 held, stall=0.
REQ-030 DEPTH=4, push 5 consecutive with out_ready=0 -> in_ready=0 after 4th, 5th not accepted, count=4.
REQ-031 Full queue, push+pop same cycle -> pop accepted, push rejected, count=3; next cycle push accepted, count=4.
REQ-032 count=3, flush with in_valid=1 -> next cycle count=0, out_valid=0, out_data=bubble (raw_instr 0, stall 1).
REQ-033 Wrap-around: 10 push/pop pairs, DEPTH=4 -> out pc sequence in order, no loss, count never exceeds 1.
REQ-034 FD_QUEUE_BYPASS_EN, empty, in_valid=1 raw_instr=0x0000_0013, out_ready=1 -> out_data same cycle, count stays 0; without macro -> visible next cycle.
